// File: rtl/floo_inject_arbiter.sv
// Round-robin injection arbiter sharing one FlooNoC router link among NumReq requesters,
// with urgent priority, packet locking and stall freezing. FLOO_INJECT_ARB_PERF_EN adds perf counters.
module floo_inject_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned MaxPktLen = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             valid_i,
  output logic [NumReq-1:0]             ready_o,
  input  logic [NumReq*FlitWidth-1:0]   flit_i,
  input  logic [NumReq-1:0]             last_i,
  input  logic [NumReq-1:0]             urgent_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [FlitWidth-1:0]          flit_o,
  output logic                          last_o,
  output logic [$clog2(NumReq)-1:0]     gnt_idx_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [NumReq*16-1:0]          perf_flits_o,
  output logic [15:0]                   perf_stall_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxPktLen + 1);

  typedef enum logic [1:0] {Idle, Offer, Locked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic            err_q, err_d;

  logic [NumReq-1:0] cand;
  logic [IdxW-1:0]   pick, eff_gnt;
  logic              pick_vld, granted, hs;
  logic [CntW-1:0]   beat_inc;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return s[IdxW-1:0];
  endfunction

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] i);
    return (i == IdxW'(NumReq - 1)) ? '0 : i + 1'b1;
  endfunction

  // Urgent requests, when present, fully replace the normal candidate set.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    cand     = (|(valid_i & urgent_i)) ? (valid_i & urgent_i) : valid_i;
    for (int i = 0; i < NumReq; i++) begin
      if (!pick_vld && cand[rr_idx(rr_q, i)]) begin
        pick     = rr_idx(rr_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    eff_gnt = (state_q == Idle) ? pick : gnt_q;
    granted = (state_q == Idle) ? pick_vld : 1'b1;
    valid_o = ~rst_i & granted & valid_i[eff_gnt];
    ready_o = '0;
    if (!rst_i && granted) ready_o[eff_gnt] = ready_i;
    flit_o    = flit_i[eff_gnt*FlitWidth +: FlitWidth];
    last_o    = last_i[eff_gnt];
    gnt_idx_o = eff_gnt;
    hs        = valid_o & ready_i;
    busy_o    = (state_q != Idle);
    err_o     = err_q;
  end

  assign beat_inc = (beat_q == '1) ? beat_q : beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      Idle: begin
        if (hs) begin
          if (last_o) begin
            rr_d = rr_next(pick);
          end else begin
            gnt_d   = pick;
            beat_d  = CntW'(1);
            state_d = Locked;
            if (MaxPktLen <= 1) err_d = 1'b1;
          end
        end else if (pick_vld) begin
          gnt_d   = pick;
          state_d = Offer;
        end
      end
      Offer: begin
        if (hs) begin
          if (last_o) begin
            rr_d    = rr_next(gnt_q);
            state_d = Idle;
          end else begin
            beat_d  = CntW'(1);
            state_d = Locked;
            if (MaxPktLen <= 1) err_d = 1'b1;
          end
        end else if (!valid_i[gnt_q]) begin
          // Offer withdrawn: re-arbitrate without advancing the pointer.
          state_d = Idle;
        end
      end
      Locked: begin
        if (hs) begin
          if (last_o) begin
            rr_d    = rr_next(gnt_q);
            beat_d  = '0;
            state_d = Idle;
          end else begin
            beat_d = beat_inc;
            if (beat_inc >= CntW'(MaxPktLen)) err_d = 1'b1;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      rr_q    <= '0;
      gnt_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

`ifdef FLOO_INJECT_ARB_PERF_EN
  logic [NumReq-1:0][15:0] perf_flits_q, perf_flits_d;
  logic [15:0]             perf_stall_q, perf_stall_d;

  always_comb begin
    perf_flits_d = perf_flits_q;
    perf_stall_d = perf_stall_q;
    for (int k = 0; k < NumReq; k++) begin
      if (hs && eff_gnt == IdxW'(k) && perf_flits_q[k] != 16'hFFFF)
        perf_flits_d[k] = perf_flits_q[k] + 16'd1;
    end
    if (valid_o && !ready_i && perf_stall_q != 16'hFFFF)
      perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_flits_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_flits_q <= perf_flits_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_flits_o = perf_flits_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_flits_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_floo_inject_arbiter.sv
// Directed bench for floo_inject_arbiter: reset, round-robin, lock, stall freeze, urgent, overlong.
module tb_floo_inject_arbiter;
  localparam int NR = 4;
  localparam int FW = 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     valid_i, ready_o, last_i, urgent_i;
  logic [NR*FW-1:0]  flit_i;
  logic              valid_o, ready_i, last_o, busy_o, err_o;
  logic [FW-1:0]     flit_o;
  logic [1:0]        gnt_idx_o;
  logic [NR*16-1:0]  perf_flits_o;
  logic [15:0]       perf_stall_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FLOO_INJECT_ARB_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  floo_inject_arbiter #(.NumReq(NR), .FlitWidth(FW), .MaxPktLen(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .flit_i(flit_i),
    .last_i(last_i), .urgent_i(urgent_i), .valid_o(valid_o), .ready_i(ready_i),
    .flit_o(flit_o), .last_o(last_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o),
    .err_o(err_o), .perf_flits_o(perf_flits_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] fv(input int k, input int beat);
    return 64'hF100_0000 + 64'(k) * 64'h100 + 64'(beat);
  endfunction

  task automatic set_flit(input int k, input int beat);
    flit_i[k*FW +: FW] = fv(k, beat);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = '1; last_i = '1; urgent_i = '0; ready_i = 1'b1; flit_i = '0;
    for (int k = 0; k < NR; k++) set_flit(k, 0);

    // Reset with all requesters valid
    tick(); tick();
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_busy_o",  64'(busy_o),  64'd0);
    chk("rst_err_o",   64'(err_o),   64'd0);
    rst_i = 1'b0;
    #1;

    // Round-robin of single-flit packets
    for (int c = 0; c < 4; c++) begin
      chk("rr_gnt",  64'(gnt_idx_o), 64'(c));
      chk("rr_flit", flit_o, fv(c, 0));
      chk("rr_rdy",  64'(ready_o), 64'(4'b0001 << c));
      tick();
    end
    for (int k = 0; k < NR; k++)
      chk("rr_perf", 64'(perf_flits_o[k*16 +: 16]), PerfOn ? 64'd1 : 64'd0);
    chk("rr_gnt_wrap", 64'(gnt_idx_o), 64'd0);
    valid_i = '0;
    tick();

    // Lock: req1 3-flit packet while req2 waits
    valid_i = 4'b0110; last_i = 4'b0100; set_flit(1, 1); set_flit(2, 1);
    #1;
    chk("lk_gnt_a",  64'(gnt_idx_o), 64'd1);
    chk("lk_flit_a", flit_o, fv(1, 1));
    chk("lk_rdy_a",  64'(ready_o), 64'b0010);
    tick();
    set_flit(1, 2); #1;
    chk("lk_gnt_b",  64'(gnt_idx_o), 64'd1);
    chk("lk_flit_b", flit_o, fv(1, 2));
    chk("lk_rdy_b",  64'(ready_o), 64'b0010);
    chk("lk_busy",   64'(busy_o), 64'd1);
    tick();
    set_flit(1, 3); last_i[1] = 1'b1; #1;
    chk("lk_flit_c", flit_o, fv(1, 3));
    chk("lk_last_c", 64'(last_o), 64'd1);
    chk("lk_rdy_c",  64'(ready_o), 64'b0010);
    tick();
    valid_i[1] = 1'b0; #1;
    chk("lk_gnt_2",  64'(gnt_idx_o), 64'd2);
    chk("lk_flit_2", flit_o, fv(2, 1));
    chk("lk_rdy_2",  64'(ready_o), 64'b0100);
    tick();
    valid_i = '0;
    tick();

    // Stall: req0 offered, 5 cycles ready_i=0, req3 goes urgent meanwhile
    valid_i = 4'b0001; last_i = '1; ready_i = 1'b0; set_flit(0, 7); set_flit(3, 7);
    #1;
    chk("st_gnt_0", 64'(gnt_idx_o), 64'd0);
    tick();
    valid_i[3] = 1'b1; urgent_i[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("st_gnt",  64'(gnt_idx_o), 64'd0);
      chk("st_flit", flit_o, fv(0, 7));
      chk("st_rdy3", 64'(ready_o[3]), 64'd0);
      tick();
    end
    chk("st_busy", 64'(busy_o), 64'd1);
    chk("st_perf", 64'(perf_stall_o), PerfOn ? 64'd5 : 64'd0);
    ready_i = 1'b1; #1;
    chk("st_acc_gnt", 64'(gnt_idx_o), 64'd0);
    chk("st_acc_rdy", 64'(ready_o), 64'b0001);
    tick();
    valid_i[0] = 1'b0; #1;
    chk("st_next_gnt", 64'(gnt_idx_o), 64'd3);
    tick();
    valid_i = '0; urgent_i = '0;
    tick();

    // Urgent: set rr_ptr=1 via req0, then 1,2,3 valid with 3 urgent
    valid_i = 4'b0001; #1;
    chk("ur_pre_gnt", 64'(gnt_idx_o), 64'd0);
    tick();
    valid_i = 4'b1110; urgent_i = 4'b1000; #1;
    chk("ur_gnt_3", 64'(gnt_idx_o), 64'd3);
    tick();
    valid_i[3] = 1'b0; urgent_i = '0; #1;
    chk("ur_gnt_1", 64'(gnt_idx_o), 64'd1);
    tick();
    valid_i = '0;
    tick();

    // Overlong: req2 sends 17 flits without last
    valid_i = 4'b0100; last_i = '0;
    for (int b = 1; b <= 17; b++) begin
      set_flit(2, b); #1;
      chk("ol_gnt", 64'(gnt_idx_o), 64'd2);
      tick();
      if (b == 15) chk("ol_err_15", 64'(err_o), 64'd0);
      if (b == 16) chk("ol_err_16", 64'(err_o), 64'd1);
    end
    valid_i[3] = 1'b1; #1;
    chk("ol_err_17",  64'(err_o), 64'd1);
    chk("ol_busy",    64'(busy_o), 64'd1);
    chk("ol_gnt_lk",  64'(gnt_idx_o), 64'd2);
    chk("ol_rdy3",    64'(ready_o[3]), 64'd0);
    last_i[2] = 1'b1; set_flit(2, 18);
    tick();
    valid_i[2] = 1'b0; #1;
    chk("ol_idle",    64'(busy_o), 64'd0);
    chk("ol_sticky",  64'(err_o), 64'd1);
    chk("ol_gnt_3",   64'(gnt_idx_o), 64'd3);
    valid_i = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; #1;
    chk("ol_err_clr", 64'(err_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
